// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt sequencing stage.
//   state_t            : sequencer states (IDLE, TAKE, ACTIVE)
//   IRQ_CAUSE_W        : width of the cause index
//   DEF_VECTOR_BASE    : default address of the cause-0 handler
//   DEF_VECTOR_STRIDE  : default byte spacing between handler entries
package interrupt_controller_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAKE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int          IRQ_CAUSE_W       = 3;
  localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
  localparam int unsigned DEF_VECTOR_STRIDE = 16;
endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and sticky pending latch for N_IRQ lines.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : raw request lines
//   clr        : per-line clear (line taken); a same-cycle edge wins
//   pending    : latched requests, independent of any enable mask
module irq_edge_latch #(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] clr,
  output logic [N_IRQ-1:0] pending
);
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] rise;

  assign rise = irq_in & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Load the live level so a line held high through reset never fires.
      prev    <= irq_in;
      pending <= '0;
    end else begin
      prev    <= irq_in;
      pending <= (pending & ~clr) | rise;
    end
  end
endmodule

// File: rtl/interrupt_controller.sv
// Non-nesting interrupt sequencer: latches request edges, picks the lowest
// enabled pending line, redirects fetch, flushes and saves the return PC
// into x30, then waits for the ISR return.
//   CLK, RESET          : clock, synchronous active-high reset
//   IRQ_IN, IRQ_ENABLE  : request lines and per-line enable
//   PIPE_STALL          : blocks a take while high (IDLE only)
//   PC_NEXT             : return address candidate
//   ISR_RETURN          : ISR return pulse from decode
//   PC_NEXT_REGFILE     : saved return address for x30
//   INTERUPT_PC_REG_EN  : x30 write strobe
//   PC_SEL, ISR_TARGET  : fetch redirect and handler address
//   FLUSH               : kill IF/ID/EX
//   ISR_ACTIVE          : handler running
//   IRQ_CAUSE           : index of taken/serviced line
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned N_IRQ         = 4,
  parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int unsigned VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_IRQ-1:0]       IRQ_IN,
  input  logic [N_IRQ-1:0]       IRQ_ENABLE,
  input  logic                   PIPE_STALL,
  input  logic [31:0]            PC_NEXT,
  input  logic                   ISR_RETURN,
  output logic [31:0]            PC_NEXT_REGFILE,
  output logic                   INTERUPT_PC_REG_EN,
  output logic                   PC_SEL,
  output logic [31:0]            ISR_TARGET,
  output logic                   FLUSH,
  output logic                   ISR_ACTIVE,
  output logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE
);
  localparam int STRIDE_SH = $clog2(VECTOR_STRIDE);

  state_t                 state, state_d;
  logic [N_IRQ-1:0]       pending, req, clr;
  logic [IRQ_CAUSE_W-1:0] winner;
  logic                   take;
  logic [31:0]            target;

  irq_edge_latch #(.N_IRQ(N_IRQ)) u_latch (
    .clk     (CLK),
    .reset   (RESET),
    .irq_in  (IRQ_IN),
    .clr     (clr),
    .pending (pending)
  );

  assign req = pending & IRQ_ENABLE;

  // Fixed priority: scanning downward leaves the lowest set index.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req[i]) winner = IRQ_CAUSE_W'(i);
  end

  assign target = VECTOR_BASE + (32'(winner) << STRIDE_SH);
  assign clr    = take ? (N_IRQ'(1) << winner) : '0;

  always_comb begin
    state_d = state;
    take    = 1'b0;
    case (state)
      IDLE:   if (|req && !PIPE_STALL) begin
                state_d = TAKE;
                take    = 1'b1;
              end
      TAKE:   state_d = ACTIVE;
      ACTIVE: if (ISR_RETURN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are clean Moore
  // outputs aligned with the TAKE/ACTIVE cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= IDLE;
      FLUSH              <= 1'b0;
      PC_SEL             <= 1'b0;
      INTERUPT_PC_REG_EN <= 1'b0;
      ISR_ACTIVE         <= 1'b0;
      PC_NEXT_REGFILE    <= '0;
      ISR_TARGET         <= '0;
      IRQ_CAUSE          <= '0;
    end else begin
      state              <= state_d;
      FLUSH              <= (state_d == TAKE);
      PC_SEL             <= (state_d == TAKE);
      INTERUPT_PC_REG_EN <= (state_d == TAKE);
      ISR_ACTIVE         <= (state_d == ACTIVE);
      if (take) begin
        PC_NEXT_REGFILE <= PC_NEXT;
        ISR_TARGET      <= target;
        IRQ_CAUSE       <= winner;
      end
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (N_IRQ=4, defaults).
module tb_interrupt_controller;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  IRQ_IN, IRQ_ENABLE;
  logic        PIPE_STALL, ISR_RETURN;
  logic [31:0] PC_NEXT;
  logic [31:0] PC_NEXT_REGFILE, ISR_TARGET;
  logic        INTERUPT_PC_REG_EN, PC_SEL, FLUSH, ISR_ACTIVE;
  logic [2:0]  IRQ_CAUSE;

  int checks = 0;
  int errors = 0;

  interrupt_controller dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .IRQ_ENABLE(IRQ_ENABLE),
    .PIPE_STALL(PIPE_STALL), .PC_NEXT(PC_NEXT), .ISR_RETURN(ISR_RETURN),
    .PC_NEXT_REGFILE(PC_NEXT_REGFILE), .INTERUPT_PC_REG_EN(INTERUPT_PC_REG_EN),
    .PC_SEL(PC_SEL), .ISR_TARGET(ISR_TARGET), .FLUSH(FLUSH),
    .ISR_ACTIVE(ISR_ACTIVE), .IRQ_CAUSE(IRQ_CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {FLUSH, PC_SEL, INTERUPT_PC_REG_EN, ISR_ACTIVE}
  function automatic logic [31:0] strb();
    return 32'({FLUSH, PC_SEL, INTERUPT_PC_REG_EN, ISR_ACTIVE});
  endfunction

  task automatic chk_take(input string tag, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [2:0] cause);
    chk({tag, "_strb"},  strb(), 32'hE);
    chk({tag, "_pc"},    PC_NEXT_REGFILE, pc);
    chk({tag, "_tgt"},   ISR_TARGET, tgt);
    chk({tag, "_cause"}, 32'(IRQ_CAUSE), 32'(cause));
  endtask

  task automatic isr_ret(input string tag);
    ISR_RETURN = 1'b1;
    tick();
    ISR_RETURN = 1'b0;
    chk({tag, "_ret"}, strb(), 32'h0);
  endtask

  initial begin
    RESET = 1'b1; IRQ_IN = 4'b0001; IRQ_ENABLE = 4'hF;
    PIPE_STALL = 1'b0; ISR_RETURN = 1'b0; PC_NEXT = 32'h0;

    // Reset with line 0 held high: nothing may fire after release.
    repeat (3) tick();
    chk("rst_strb",  strb(), 32'h0);
    chk("rst_pc",    PC_NEXT_REGFILE, 32'h0);
    chk("rst_tgt",   ISR_TARGET, 32'h0);
    chk("rst_cause", 32'(IRQ_CAUSE), 32'h0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_held_line", strb(), 32'h0);
    end
    IRQ_IN = 4'b0000;
    tick();

    // Single request on line 2.
    IRQ_IN = 4'b0100; PC_NEXT = 32'h40;
    tick();
    chk("l2_latch", strb(), 32'h0);
    tick();
    chk_take("l2", 32'h40, 32'h120, 3'd2);
    IRQ_IN = 4'b0000; PC_NEXT = 32'h44;
    tick();
    chk("l2_active", strb(), 32'h1);
    tick();
    chk("l2_hold_pc", PC_NEXT_REGFILE, 32'h40);
    isr_ret("l2");

    // Lines 1 and 3 together: 1 first, 3 right after return.
    IRQ_IN = 4'b1010; PC_NEXT = 32'h80;
    tick();
    tick();
    chk_take("l1", 32'h80, 32'h110, 3'd1);
    IRQ_IN = 4'b0000; PC_NEXT = 32'h90;
    repeat (3) tick();
    chk("l1_active", strb(), 32'h1);
    isr_ret("l1");
    tick();
    chk_take("l3", 32'h90, 32'h130, 3'd3);
    tick();
    chk("l3_active", strb(), 32'h1);
    isr_ret("l3");

    // Masked edge on line 0 stays latched until enabled.
    IRQ_ENABLE = 4'b1110; IRQ_IN = 4'b0001; PC_NEXT = 32'hA0;
    tick();
    IRQ_IN = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mask_idle", strb(), 32'h0);
    end
    IRQ_ENABLE = 4'hF;
    tick();
    chk_take("l0", 32'hA0, 32'h100, 3'd0);
    tick();
    isr_ret("l0");

    // Three stalled cycles delay the take by exactly three.
    PIPE_STALL = 1'b1; IRQ_IN = 4'b0100; PC_NEXT = 32'h200;
    tick();
    for (int i = 0; i < 3; i++) begin
      PC_NEXT = 32'h204 + 32'(i * 4);
      tick();
      chk("stall_hold", strb(), 32'h0);
    end
    PIPE_STALL = 1'b0; PC_NEXT = 32'h300;
    tick();
    chk_take("stall", 32'h300, 32'h120, 3'd2);
    IRQ_IN = 4'b0000;
    tick();
    isr_ret("stall");

    // New edge on line 2 at the very edge it is taken: set wins.
    PIPE_STALL = 1'b1; IRQ_IN = 4'b0100; PC_NEXT = 32'h400;
    tick();
    IRQ_IN = 4'b0000;
    tick();
    PIPE_STALL = 1'b0; IRQ_IN = 4'b0100;
    tick();
    chk_take("setwin1", 32'h400, 32'h120, 3'd2);
    PC_NEXT = 32'h500;
    tick();
    isr_ret("setwin");
    tick();
    chk_take("setwin2", 32'h500, 32'h120, 3'd2);
    IRQ_IN = 4'b0000;
    tick();
    isr_ret("setwin2");

    // Reset during TAKE aborts and clears pending.
    IRQ_IN = 4'b1010; PC_NEXT = 32'h600;
    tick();
    tick();
    chk("abort_take", strb(), 32'hE);
    RESET = 1'b1;
    tick();
    chk("abort_strb", strb(), 32'h0);
    chk("abort_pc",   PC_NEXT_REGFILE, 32'h0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_idle", strb(), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
